timer_irq: RTL and testbench

- Memory-mapped down-counting timer that wakes the Tiny32 core out of WFI.
- Responder end of the core's interrupt request/acknowledge interface.
- The core programs it over the peripheral bus. The timer raises irq on expiry and holds it until irq_ack.
- Replaces the free-running blink timer with a programmable, interrupt-driven one.

---
 rtl/timer_irq_if.sv | 13 +
 rtl/timer_irq.sv | 134 +++++++++++++
 tb/tb_timer_irq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_irq_if.sv
// Peripheral bus plus interrupt request/acknowledge pair between the core and timer_irq.
interface timer_irq_if;
  logic        sel;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        irq_ack;

  modport master (output sel, wr, addr, wdata, irq_ack, input rdata, irq);
  modport slave  (input sel, wr, addr, wdata, irq_ack, output rdata, irq);
endinterface

// File: rtl/timer_irq.sv
// Programmable down-counting timer with latched interrupt, one-shot or auto-reload.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_irq #(
  parameter int TIMER_BITS     = 16,
  parameter int PRESCALER_BITS = 8
) (
  input logic        clk,
  input logic        nrst,
  timer_irq_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_n;
  logic                  auto_rl, auto_n, ie, ie_n;
  logic                  pend, pend_n, ovr, ovr_n, irq;
  logic [TIMER_BITS-1:0] load, load_n, count, count_n;
  logic [31:0]           rdata, rdata_n;
  logic                  wr_hit, rd_hit, start, tick, expire, pend_clr;
  logic [7:0]            psc_rd;
  logic                  unused_wdata;

  assign wr_hit       = bus.sel & bus.wr;
  assign rd_hit       = bus.sel & ~bus.wr;
  assign start        = wr_hit && bus.addr == 2'd0 && bus.wdata[0] && state == IDLE;
  assign expire       = tick && count == '0;
  assign pend_clr     = bus.irq_ack | (wr_hit && bus.addr == 2'd3 && bus.wdata[0]);
  assign bus.rdata    = rdata;
  assign bus.irq      = irq;
  assign unused_wdata = ^bus.wdata;

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALER_BITS-1:0] psc, psc_n, pcnt, pcnt_n;

  assign tick   = state == RUN && pcnt == psc;
  assign psc_rd = 8'(psc);

  always_comb begin
    psc_n  = psc;
    pcnt_n = pcnt;
    if (state == RUN) pcnt_n = tick ? '0 : pcnt + 1'b1;
    if (start) pcnt_n = '0;
    if (wr_hit && bus.addr == 2'd3) psc_n = PRESCALER_BITS'(bus.wdata[15:8]);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      psc  <= '0;
      pcnt <= '0;
    end else begin
      psc  <= psc_n;
      pcnt <= pcnt_n;
    end
  end
`else
  logic [PRESCALER_BITS-1:0] unused_psc;

  assign unused_psc = '0;
  assign tick       = state == RUN;
  assign psc_rd     = 8'd0;
`endif

  always_comb begin
    state_n = state;
    auto_n  = auto_rl;
    ie_n    = ie;
    load_n  = load;
    count_n = count;
    pend_n  = pend;
    ovr_n   = ovr;
    rdata_n = rdata;

    // Zero is expiry, so the decrement below never wraps.
    if (tick) begin
      if (count != '0)  count_n = count - 1'b1;
      else if (auto_rl) count_n = load;
      else              state_n = IDLE;
    end

    // Bus writes are applied after the tick so they override it.
    if (wr_hit) begin
      case (bus.addr)
        2'd0: begin
          state_n = bus.wdata[0] ? RUN : IDLE;
          auto_n  = bus.wdata[1];
          ie_n    = bus.wdata[2];
          if (start) count_n = load;
        end
        2'd1:    load_n  = bus.wdata[TIMER_BITS-1:0];
        2'd2:    count_n = bus.wdata[TIMER_BITS-1:0];
        default: if (bus.wdata[1]) ovr_n = 1'b0;
      endcase
    end

    // Expiry beats a same-cycle clear; overrun only if PEND survives into it.
    if (pend_clr) pend_n = 1'b0;
    if (expire) begin
      pend_n = 1'b1;
      if (pend && !pend_clr) ovr_n = 1'b1;
    end

    if (rd_hit) begin
      case (bus.addr)
        2'd0:    rdata_n = {29'd0, ie, auto_rl, state == RUN};
        2'd1:    rdata_n = 32'(load);
        2'd2:    rdata_n = 32'(count);
        default: rdata_n = {16'd0, psc_rd, 6'd0, ovr, pend};
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      load    <= '0;
      count   <= '0;
      pend    <= 1'b0;
      ovr     <= 1'b0;
      irq     <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_n;
      auto_rl <= auto_n;
      ie      <= ie_n;
      load    <= load_n;
      count   <= count_n;
      pend    <= pend_n;
      ovr     <= ovr_n;
      irq     <= pend & ie;
      rdata   <= rdata_n;
    end
  end
endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: expiry timing predicted arithmetically, registers via a shadow map.
module tb_timer_irq;
  localparam int TB_BITS = 16;
`ifdef TIMER_PRESCALER_EN
  localparam bit PSC_ON = 1'b1;
`else
  localparam bit PSC_ON = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_irq_if bus ();
  timer_irq #(.TIMER_BITS(TB_BITS), .PRESCALER_BITS(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(posedge clk); #1;
    d = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    @(posedge clk); #1;
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0; #2; nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_irq(input int bound);
    int i = 0;
    while (!bus.irq && i < bound) begin @(posedge clk); #1; i++; end
  endtask

  task automatic quiet(input int n, input string tag);
    int hi = 0;
    repeat (n) begin @(posedge clk); #1; if (bus.irq) hi++; end
    chk(tag, hi, 0);
  endtask

  // Auto-reload: rises expected at c0 + k*P + 1 with P = (LOAD+1)*(PSC+1).
  task automatic run_auto(input int l, input int psc, input string tag);
    int c0, p;
    do_reset();
    if (PSC_ON) wr_reg(2'd3, 32'(psc) << 8);
    p = (l + 1) * (PSC_ON ? psc + 1 : 1);
    wr_reg(2'd1, 32'(l));
    wr_reg(2'd0, 32'h7);
    c0 = cyc;
    wait_irq(4 * p + 8);
    chk({tag, "_first"}, cyc - c0, p + 1);
    ack();
    step(1);
    wait_irq(4 * p + 8);
    chk({tag, "_second"}, cyc - c0, 2 * p + 1);
  endtask

  initial begin
    logic [31:0] d, e;
    logic [31:0] shadow [4];
    int l, c0;

    bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0; bus.irq_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_irq", bus.irq, 0);
    chk("rst_rdata", bus.rdata, 0);
    nrst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 0);
    end

    // Reset mid-run
    wr_reg(2'd1, 32'd5);
    wr_reg(2'd0, 32'h7);
    rd_reg(2'd1, d);
    chk("load_rd", d, 5);
    step(8);
    chk("pre_rst_irq", bus.irq, 1);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_irq", bus.irq, 0);
    chk("async_rst_rdata", bus.rdata, 0);
    #1 nrst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), d);
      chk($sformatf("post_rst_reg%0d", a), d, 0);
    end
    quiet(100, "post_rst_quiet");

    // Shadow register map, EN kept 0 so COUNT is frozen
    shadow = '{default: 32'd0};
    for (int i = 0; i < 16; i++) begin
      int a;
      a = $urandom_range(0, 2);
      d = $urandom;
      if (a == 0) d = d & 32'h6;
      wr_reg(2'(a), d);
      shadow[a] = (a == 0) ? d : (d & ((32'd1 << TB_BITS) - 1));
      rd_reg(2'(a), e);
      chk($sformatf("shadow_a%0d", a), e, shadow[a]);
    end

    // One-shot: PEND after LOAD+1 ticks, irq one cycle later
    for (int it = 0; it < 4; it++) begin
      do_reset();
      l = (it == 0) ? 3 : int'($urandom_range(0, 12));
      wr_reg(2'd1, 32'(l));
      wr_reg(2'd0, 32'h5);
      c0 = cyc;
      wait_irq(40);
      chk("oneshot_lat", cyc - c0, l + 2);
      rd_reg(2'd0, d); chk("oneshot_ctrl", d, 32'h4);
      rd_reg(2'd2, d); chk("oneshot_count", d, 0);
      rd_reg(2'd3, d); chk("oneshot_status", d, 1);
      ack();
      chk("ack_irq_hold", bus.irq, 1);
      step(1);
      chk("ack_irq_fall", bus.irq, 0);
      rd_reg(2'd3, d); chk("ack_status", d, 0);
    end

    run_auto(9, 0, "auto10");
    run_auto(int'($urandom_range(2, 15)), int'($urandom_range(0, 5)), "auto_rand");

    // Two unacked expiries -> PEND and OVR
    do_reset();
    wr_reg(2'd1, 32'd9);
    wr_reg(2'd0, 32'h7);
    step(25);
    rd_reg(2'd3, d); chk("ovr_status", d, 32'h3);
    wr_reg(2'd0, 32'h0);
    wr_reg(2'd3, 32'h3);
    rd_reg(2'd3, d); chk("w1c_status", d, 0);

    // LOAD=0 expires every tick; held ack never wins over expiry
    do_reset();
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd0, 32'h3);
    step(3);
    rd_reg(2'd3, d); chk("load0_ovr", d, 32'h3);
    bus.irq_ack = 1'b1;
    wr_reg(2'd3, 32'h3);
    step(2);
    rd_reg(2'd3, d); chk("ack_vs_expiry", d, 32'h1);
    bus.irq_ack = 1'b0;

    // COUNT write while running
    do_reset();
    wr_reg(2'd1, 32'd20);
    wr_reg(2'd0, 32'h7);
    step(3);
    wr_reg(2'd2, 32'd7);
    c0 = cyc;
    wait_irq(40);
    chk("count_wr_lat", cyc - c0, 9);

    // IE masking
    do_reset();
    wr_reg(2'd1, 32'd2);
    wr_reg(2'd0, 32'h1);
    quiet(6, "masked_quiet");
    rd_reg(2'd3, d); chk("masked_pend", d, 1);
    rd_reg(2'd0, d); chk("masked_ctrl", d, 0);
    wr_reg(2'd0, 32'h4);
    chk("ie_set_lag", bus.irq, 0);
    step(1);
    chk("ie_set_irq", bus.irq, 1);
    wr_reg(2'd0, 32'h0);
    step(1);
    chk("ie_clr_irq", bus.irq, 0);
    rd_reg(2'd3, d); chk("ie_clr_pend", d, 1);

    // Prescaler register and period
    do_reset();
    wr_reg(2'd3, 32'h0300);
    rd_reg(2'd3, d);
    chk("psc_rd", d, PSC_ON ? 32'h0300 : 32'h0);
    run_auto(4, 3, "psc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
